// File: rtl/tld_pkg.sv
// Shared types and lamp-pattern helpers for the tail-light pattern decoder.
package tld_pkg;

    localparam logic [2:0] PAT_Z  = 3'b000;
    localparam logic [2:0] PAT_S1 = 3'b001;
    localparam logic [2:0] PAT_S2 = 3'b011;
    localparam logic [2:0] PAT_F  = 3'b111;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        LEFT   = 3'd1,
        RIGHT  = 3'd2,
        HAZARD = 3'd3,
        DUAL   = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Successor in the turn chain Z->S1->S2->F->Z. Anything outside the chain maps to Z,
    // which is the only step that is legal from an unknown pattern.
    function automatic logic [2:0] next_turn_pat(input logic [2:0] pat);
        logic [2:0] nxt;
        case (pat)
            PAT_Z:   nxt = PAT_S1;
            PAT_S1:  nxt = PAT_S2;
            PAT_S2:  nxt = PAT_F;
            default: nxt = PAT_Z;
        endcase
        return nxt;
    endfunction

    function automatic logic is_legal_pat(input logic [2:0] pat);
        return (pat == PAT_Z) || (pat == PAT_S1) || (pat == PAT_S2) || (pat == PAT_F);
    endfunction

endpackage

// File: rtl/tld_side_tracker.sv
// Per-side lamp group tracker: remembers the previous sample and qualifies the current
// one against the turn chain and the hazard alternation.
module tld_side_tracker
    import tld_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] pat_i,
    output logic       is_legal_o,
    output logic       is_zero_o,
    output logic       prev_zero_o,
    output logic       is_start_o,
    output logic       turn_ok_o,
    output logic       hazard_ok_o,
    output logic       wrap_o
);

    logic [2:0] prev_q;

    // Previous sample, taken every edge regardless of decoder state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= PAT_Z;
        else       prev_q <= pat_i;
    end

    // Qualifiers of the current sample relative to the previous one.
    always_comb begin
        is_legal_o  = is_legal_pat(pat_i);
        is_zero_o   = (pat_i == PAT_Z);
        prev_zero_o = (prev_q == PAT_Z);
        is_start_o  = (prev_q == PAT_Z) && (pat_i != PAT_Z);
        turn_ok_o   = (pat_i == next_turn_pat(prev_q)) || (pat_i == PAT_Z);
        hazard_ok_o = (pat_i == PAT_Z) || ((prev_q == PAT_Z) && (pat_i == PAT_F));
        wrap_o      = (prev_q == PAT_F) && (pat_i == PAT_Z);
    end

endmodule

// File: rtl/taillight_pattern_decoder.sv
// Tail-light lamp bus decoder: classifies the 3+3 lamp pattern into OFF/LEFT/RIGHT/DUAL/HAZARD,
// locks the mode after LOCK_CYCLES conforming samples and flags illegal patterns/steps.
// Optional feature macro: TAILLIGHT_DEC_ERRCNT_EN adds a saturating 8-bit err_count output.
//
// state  | meaning
// IDLE   | no candidate; waiting for a legal first non-zero sample after an all-zero sample
// ACQ    | candidate chosen; counting conforming samples toward lock
// LOCKED | mode locked and reported; mode_valid=1
module taillight_pattern_decoder
    import tld_pkg::*;
#(
    parameter int LOCK_CYCLES = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] l_in,
    input  logic [2:0] r_in,
    output logic [2:0] mode,
    output logic       mode_valid,
    output logic       seq_done,
    output logic       err
`ifdef TAILLIGHT_DEC_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // With a lock window of one, the start sample alone is enough to lock.
    localparam state_e START_STATE = (LOCK_CYCLES <= 1) ? LOCKED : ACQ;

    logic l_legal, l_zero, l_prev_zero, l_start, l_turn, l_haz, l_wrap;
    logic r_legal, r_zero, r_prev_zero, r_start, r_turn, r_haz, r_wrap;

    tld_side_tracker u_left (
        .clk         (clk),
        .reset       (reset),
        .pat_i       (l_in),
        .is_legal_o  (l_legal),
        .is_zero_o   (l_zero),
        .prev_zero_o (l_prev_zero),
        .is_start_o  (l_start),
        .turn_ok_o   (l_turn),
        .hazard_ok_o (l_haz),
        .wrap_o      (l_wrap)
    );

    tld_side_tracker u_right (
        .clk         (clk),
        .reset       (reset),
        .pat_i       (r_in),
        .is_legal_o  (r_legal),
        .is_zero_o   (r_zero),
        .prev_zero_o (r_prev_zero),
        .is_start_o  (r_start),
        .turn_ok_o   (r_turn),
        .hazard_ok_o (r_haz),
        .wrap_o      (r_wrap)
    );

    state_e           state_q, state_d;
    mode_e            cand_q, cand_d;
    mode_e            mode_q, mode_d;
    logic             mode_valid_q, mode_valid_d;
    logic             seq_done_q, seq_done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] lock_inc;

    logic  pat_legal, all_zero, first_nz, idle_timeout;
    logic  start_ok, conform;
    mode_e start_cls;

    // Candidate classification of the current sample and conformance to the held candidate.
    always_comb begin
        pat_legal = l_legal && r_legal;
        all_zero  = l_zero && r_zero;
        first_nz  = (l_start || r_start) && l_prev_zero && r_prev_zero;

        start_ok  = 1'b1;
        start_cls = OFF;
        if      ((l_in == PAT_S1) && (r_in == PAT_Z))  start_cls = LEFT;
        else if ((l_in == PAT_Z)  && (r_in == PAT_S1)) start_cls = RIGHT;
        else if ((l_in == PAT_S1) && (r_in == PAT_S1)) start_cls = DUAL;
        else if ((l_in == PAT_F)  && (r_in == PAT_F))  start_cls = HAZARD;
        else                                           start_ok  = 1'b0;

        case (cand_q)
            LEFT:    conform = r_zero && l_turn;
            RIGHT:   conform = l_zero && r_turn;
            DUAL:    conform = (l_in == r_in) && l_turn && r_turn;
            HAZARD:  conform = (l_in == r_in) && l_haz && r_haz;
            default: conform = 1'b0;
        endcase
    end

    // Run counters: idle counts consecutive all-zero samples; both saturate.
    always_comb begin
        lock_inc     = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + CNT_ONE;
        idle_cnt_d   = '0;
        if (all_zero) idle_cnt_d = (idle_cnt_q >= IDLE_MAX) ? IDLE_MAX : idle_cnt_q + CNT_ONE;
        idle_timeout = all_zero && (idle_cnt_d >= IDLE_MAX);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cand_q       <= OFF;
            lock_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            mode_q       <= OFF;
            mode_valid_q <= 1'b0;
            seq_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            lock_cnt_q   <= lock_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            mode_q       <= mode_d;
            mode_valid_q <= mode_valid_d;
            seq_done_q   <= seq_done_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic; an illegal pattern overrides every other condition.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        lock_cnt_d = lock_cnt_q;
        err_d      = 1'b0;
        seq_done_d = 1'b0;
        if (!pat_legal) begin
            err_d      = 1'b1;
            state_d    = IDLE;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (first_nz) begin
                        if (start_ok) begin
                            cand_d     = start_cls;
                            lock_cnt_d = CNT_ONE;
                            state_d    = START_STATE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ACQ, LOCKED: begin
                    if (first_nz && start_ok && (start_cls != cand_q)) begin
                        cand_d     = start_cls;
                        lock_cnt_d = CNT_ONE;
                        state_d    = START_STATE;
                    end else if (!conform) begin
                        err_d      = 1'b1;
                        state_d    = IDLE;
                        lock_cnt_d = '0;
                    end else if (idle_timeout) begin
                        state_d    = IDLE;
                        lock_cnt_d = '0;
                    end else if (state_q == ACQ) begin
                        lock_cnt_d = lock_inc;
                        if (lock_inc >= LOCK_MAX) state_d = LOCKED;
                    end else begin
                        seq_done_d = l_wrap || r_wrap;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs land on the sampling edge.
    always_comb begin
        mode_valid_d = (state_d == LOCKED);
        mode_d       = (state_d == LOCKED) ? cand_d : OFF;
    end

    assign mode       = mode_q;
    assign mode_valid = mode_valid_q;
    assign seq_done   = seq_done_q;
    assign err        = err_q;

`ifdef TAILLIGHT_DEC_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of err pulses, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              err_cnt_q <= 8'd0;
        else if (err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_count = err_cnt_q;
`endif

endmodule
